// File: rtl/rsa_decrypt_sqm_if.sv
`default_nettype none
// ============================================================================
// Module   : rsa_decrypt_sqm_if
// Purpose  : Request/response bundle for the square-and-multiply RSA
//            decryptor. The requester drives start/c/d/n and receives
//            m/finish/busy/err back.
// Revision : 1.0 - initial release
// ============================================================================
interface rsa_decrypt_sqm_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [2*WIDTH-1:0]   c;
  logic [2*WIDTH-1:0]   d;
  logic [2*WIDTH-1:0]   n;
  logic [2*WIDTH-1:0]   m;
  logic                 finish;
  logic                 busy;
  logic                 err;

  modport master (output start, c, d, n, input  m, finish, busy, err);
  modport slave  (input  start, c, d, n, output m, finish, busy, err);
endinterface
`default_nettype wire

// File: rtl/rsa_decrypt_sqm.sv
`default_nettype none
// ============================================================================
// Module   : rsa_decrypt_sqm
// Purpose  : m = c^d mod n by left-to-right square-and-multiply over every
//            bit of d (MSB first). Each modular product is an interleaved
//            shift-add reduction taking exactly L = 2*WIDTH cycles.
// Options  : RSA_DECRYPT_CONST_TIME_EN - run the multiply step for every
//            exponent bit and discard it for zero bits, so timing no longer
//            depends on the popcount of d.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_decrypt_sqm #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rsa_decrypt_sqm_if.slave  bus
);

  localparam int L     = 2 * WIDTH;
  localparam int IDX_W = $clog2(L);
  localparam int P_W   = L + 2;
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(L - 1);
  localparam logic [L-1:0]     C_ONE  = L'(1);
  localparam logic [L-1:0]     C_TWO  = L'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SQR  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [L-1:0]     r_c;
  logic [L-1:0]     r_d;
  logic [L-1:0]     r_n;
  logic [L-1:0]     r_acc;
  logic [L-1:0]     r_m;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_cnt;
  logic [P_W-1:0]   r_prod;
  logic             r_finish;
  logic             r_busy;
  logic             r_err;

  logic             w_mbit;
  logic [P_W-1:0]   w_n_ext;
  logic [P_W-1:0]   w_sum;
  logic [P_W-1:0]   w_sub1;
  logic [P_W-1:0]   w_res;

  // One shift-add reduction step. The multiplicand is always acc (< n), so
  // 2r + acc < 3n and two conditional subtractions bring the result below n.
  // The multiplier is acc for squaring and the latched ciphertext for MUL.
  always_comb begin
    w_mbit  = (r_state == S_SQR) ? r_acc[r_cnt] : r_c[r_cnt];
    w_n_ext = {2'b00, r_n};
    w_sum   = (r_prod << 1) + (w_mbit ? {2'b00, r_acc} : {P_W{1'b0}});
    w_sub1  = (w_sum  >= w_n_ext) ? (w_sum  - w_n_ext) : w_sum;
    w_res   = (w_sub1 >= w_n_ext) ? (w_sub1 - w_n_ext) : w_sub1;
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_c      <= '0;
      r_d      <= '0;
      r_n      <= '0;
      r_acc    <= '0;
      r_m      <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_finish <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_c    <= bus.c;
            r_d    <= bus.d;
            r_n    <= bus.n;
            r_acc  <= C_ONE;
            r_idx  <= C_LAST;
            r_cnt  <= C_LAST;
            r_prod <= '0;
            r_busy <= 1'b1;
            if (bus.n < C_TWO) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= S_SQR;
            end
          end
        end

        S_SQR: begin
          if (r_cnt == '0) begin
            r_acc  <= w_res[L-1:0];
            r_prod <= '0;
            r_cnt  <= C_LAST;
`ifdef RSA_DECRYPT_CONST_TIME_EN
            r_state <= S_MUL;
`else
            if (r_d[r_idx]) begin
              r_state <= S_MUL;
            end else if (r_idx == '0) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_state <= S_SQR;
            end
`endif
          end else begin
            r_prod <= w_res;
            r_cnt  <= r_cnt - 1'b1;
          end
        end

        S_MUL: begin
          if (r_cnt == '0) begin
`ifdef RSA_DECRYPT_CONST_TIME_EN
            // Product computed unconditionally; kept only for set bits.
            if (r_d[r_idx]) begin
              r_acc <= w_res[L-1:0];
            end
`else
            r_acc <= w_res[L-1:0];
`endif
            r_prod <= '0;
            r_cnt  <= C_LAST;
            if (r_idx == '0) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_state <= S_SQR;
            end
          end else begin
            r_prod <= w_res;
            r_cnt  <= r_cnt - 1'b1;
          end
        end

        S_DONE: begin
          r_m      <= r_err ? '0 : r_acc;
          r_finish <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m      = r_m;
  assign bus.finish = r_finish;
  assign bus.busy   = r_busy;
  assign bus.err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rsa_decrypt_sqm.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_decrypt_sqm
// Purpose  : Self-checking bench for rsa_decrypt_sqm: directed RSA vectors,
//            error/abort/ignored-start scenarios and random operands checked
//            against a plain-arithmetic modular exponentiation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_decrypt_sqm;

  localparam int WIDTH = 8;
  localparam int L     = 2 * WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  rsa_decrypt_sqm_if #(.WIDTH(WIDTH)) bus ();

  rsa_decrypt_sqm #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: c^d mod n, exponent bits MSB first, straight integer math.
  function automatic logic [L-1:0] modexp(input logic [L-1:0] b, input logic [L-1:0] e,
                                          input logic [L-1:0] nn);
    longint unsigned acc;
    longint unsigned base;
    longint unsigned md;
    acc  = 1;
    base = longint'(b);
    md   = longint'(nn);
    for (int i = L - 1; i >= 0; i--) begin
      acc = (acc * acc) % md;
      if (e[i]) acc = (acc * base) % md;
    end
    return L'(acc);
  endfunction

  // Cycles from the accepting edge to the edge after which finish is seen.
  function automatic int exp_lat(input logic [L-1:0] dd);
`ifdef RSA_DECRYPT_CONST_TIME_EN
    return 1 + L * (2 * L);
`else
    return 1 + L * (L + $countones(dd));
`endif
  endfunction

  task automatic launch(input logic [L-1:0] cc, input logic [L-1:0] dd, input logic [L-1:0] nn);
    @(negedge clk);
    bus.c     = cc;
    bus.d     = dd;
    bus.n     = nn;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [L-1:0] cc, input logic [L-1:0] dd,
                       input logic [L-1:0] nn, input int poke, input logic [L-1:0] em,
                       input logic ee, input int el);
    int lat;
    bit seen;
    launch(cc, dd, nn);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    if (!ee) check({tag, "_err_clr"}, 32'(bus.err), 32'd0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 700) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.finish) seen = 1'b1;
      if (poke > 0 && lat == poke - 1) begin
        bus.start = 1'b1;
        bus.c     = ~cc;
        bus.d     = 16'h0001;
        bus.n     = 16'd1;
      end
      if (poke > 0 && lat == poke) bus.start = 1'b0;
    end
    check({tag, "_seen"},   32'(seen),     32'd1);
    check({tag, "_lat"},    32'(lat),      32'(el));
    check({tag, "_m"},      32'(bus.m),    32'(em));
    check({tag, "_err"},    32'(bus.err),  32'(ee));
    check({tag, "_idle"},   32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_pulse1"}, 32'(bus.finish), 32'd0);
    check({tag, "_mhold"},  32'(bus.m),      32'(em));
  endtask

  // Directed and random scenarios, run in sequence.
  initial begin
    logic [L-1:0] cc;
    logic [L-1:0] dd;
    logic [L-1:0] nn;
    bit seen;

    bus.start = 1'b0;
    bus.c     = '0;
    bus.d     = '0;
    bus.n     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m",      32'(bus.m),      32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_finish", 32'(bus.finish), 32'd0);
    check("rst_err",    32'(bus.err),    32'd0);
    @(negedge clk) rst_n = 1'b1;

`ifdef RSA_DECRYPT_CONST_TIME_EN
    do_op("rsa_vec", 16'd2790, 16'd2753, 16'd3233, 0, 16'd65, 1'b0, 513);
    do_op("d_zero",  16'd1234, 16'd0,    16'd3233, 0, 16'd1,  1'b0, 513);
`else
    do_op("rsa_vec", 16'd2790, 16'd2753, 16'd3233, 0, 16'd65, 1'b0, 337);
    do_op("d_zero",  16'd1234, 16'd0,    16'd3233, 0, 16'd1,  1'b0, 257);
`endif

    do_op("n_one", 16'd5, 16'd7, 16'd1, 0, 16'd0, 1'b1, 1);
    check("err_sticky", 32'(bus.err), 32'd1);
    do_op("after_err", 16'd2790, 16'd2753, 16'd3233, 0, 16'd65, 1'b0, exp_lat(16'd2753));

    do_op("ignore_start", 16'd2790, 16'd2753, 16'd3233, 50, 16'd65, 1'b0, exp_lat(16'd2753));

    // Reset 100 cycles into an operation: no finish, outputs cleared.
    launch(16'd2790, 16'd2753, 16'd3233);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.finish) seen = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy",   32'(bus.busy),   32'd0);
    check("abort_m",      32'(bus.m),      32'd0);
    check("abort_finish", 32'(bus.finish), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (bus.finish) seen = 1'b1;
    end
    check("abort_no_finish", 32'(seen),     32'd0);
    check("abort_idle",      32'(bus.busy), 32'd0);
    do_op("restart", 16'd2790, 16'd2753, 16'd3233, 0, 16'd65, 1'b0, exp_lat(16'd2753));

    do_op("d_one",  16'd2790, 16'h0001, 16'd3233, 0, modexp(16'd2790, 16'h0001, 16'd3233),
          1'b0, exp_lat(16'h0001));
    do_op("d_ffff", 16'd2790, 16'hFFFF, 16'd3233, 0, modexp(16'd2790, 16'hFFFF, 16'd3233),
          1'b0, exp_lat(16'hFFFF));
    do_op("c_zero", 16'd0, 16'd5, 16'd3233, 0, 16'd0, 1'b0, exp_lat(16'd5));
    do_op("n_max",  16'hFFFE, 16'hFFFF, 16'hFFFF, 0, modexp(16'hFFFE, 16'hFFFF, 16'hFFFF),
          1'b0, exp_lat(16'hFFFF));

    for (int i = 0; i < 6; i++) begin
      nn = 16'($urandom_range(2, 65535));
      cc = 16'($urandom % 32'(nn));
      dd = 16'($urandom);
      do_op("rand", cc, dd, nn, 0, modexp(cc, dd, nn), 1'b0, exp_lat(dd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rsa_decrypt_sqm.md
RSA_DECRYPT_SQM -- requirements
Module: rsa_decrypt_sqm

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8; datapath operand width = 2*WIDTH (= L below).
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request pulse, sampled only in IDLE.
REQ-005 The block SHALL have port c, input, L, ciphertext from encrypt stage, c < n.
REQ-006 The block SHALL have port d, input, L, private exponent.
REQ-007 The block SHALL have port n, input, L, modulus.
REQ-008 The block SHALL have port m, output, L, recovered message, registered.
REQ-009 The block SHALL have port finish, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have port busy, output, 1, high in every non-IDLE state.
REQ-011 The block SHALL have port err, output, 1, high with finish when n < 2.

Function
REQ-012 The block SHALL compute m = c^d mod n by left-to-right square-and-multiply over all L bits of d, MSB first, leading zeros included.
REQ-013 The block SHALL use states IDLE, SQR, MUL, DONE.
REQ-014 In IDLE with start=1, the block SHALL latch c, d, n, set acc=1 and bit index=L-1, then go to SQR; go to DONE with err=1 instead if n < 2.
REQ-015 SQR SHALL compute acc = acc*acc mod n, then go to MUL if d[idx]=1, else finish the bit.
REQ-016 MUL SHALL compute acc = acc*c mod n, then finish the bit.
REQ-017 Finishing a bit SHALL decrement idx and go to SQR, or go to DONE when idx was 0.
REQ-018 Each modular multiply SHALL be interleaved shift-add over L cycles, multiplier bits MSB first: r = 2r + bit*a, then at most two conditional subtractions of n; internal width L+2; result < n.
REQ-019 DONE SHALL last one cycle: load m (0 when err), pulse finish, drop busy, return to IDLE.
REQ-020 Latency SHALL be: start sampled at edge T, finish high in cycle T+1+L*(L+k), with k = popcount(d); if n < 2, finish is high in cycle T+1.
REQ-021 start while busy SHALL be ignored; inputs SHALL NOT be sampled outside IDLE.
REQ-022 m SHALL hold its value until the next DONE; err SHALL clear on the next accepted start.
REQ-023 d=0 SHALL give m=1 (n >= 2); c=0 with d != 0 SHALL give m=0.

Reset
REQ-024 While rst_n=0, state SHALL be IDLE, and m, acc, finish, busy and err SHALL be 0.
REQ-025 Reset mid-operation SHALL abort without a finish pulse; the first start after release SHALL run a full new operation.

Configuration
REQ-026 With macro RSA_DECRYPT_CONST_TIME_EN defined, MUL SHALL run for every bit and its result SHALL be discarded when d[idx]=0, so k = L in REQ-020 for all d.
REQ-027 Without RSA_DECRYPT_CONST_TIME_EN, MUL SHALL be skipped for zero bits (data-dependent timing, the timing side-channel target).

Verification
REQ-028 The bench SHALL cover: WIDTH=8, n=3233, d=2753, c=2790, start at T -> m=65, err=0, finish at T+337; at T+513 with CONST_TIME_EN.
REQ-029 The bench SHALL cover: n=3233, d=0, c=1234 -> m=1, finish at T+257.
REQ-030 The bench SHALL cover: n=1, any c/d -> finish and err at T+1, m=0; the next valid start -> err=0.
REQ-031 The bench SHALL cover: start pulsed again at T+50 during REQ-028 run -> ignored; single finish at T+337, m=65.
REQ-032 The bench SHALL cover: rst_n low at T+100 during REQ-028 run -> no finish, m=0, busy=0; a restart gives m=65.
REQ-033 The bench SHALL cover: CONST_TIME_EN, d=1 vs d=0xFFFF, same n/c -> both finish at T+513.
